// File: rtl/rv2t_prefetch_queue.sv
// Sequential instruction prefetcher: keeps up to DEPTH {PC, IR} words in order,
// with at most one memory read in flight and redirect handling for stale responses.
module rv2t_prefetch_queue #(
    parameter int               XLEN        = 32,
    parameter int               PC_BITWIDTH = 32,
    parameter int               DEPTH       = 4,
    parameter logic [XLEN-1:0]  NOP_WORD    = XLEN'(32'h0000_0013)
) (
    input  logic                    clk,
    input  logic                    sync_reset,
    input  logic                    fetch_init,
    input  logic [PC_BITWIDTH-1:0]  start_addr,
    input  logic                    fetch_next,
    output logic                    fetch_enable_out,
    output logic [XLEN-1:0]         IR_out,
    output logic [PC_BITWIDTH-1:0]  PC_out,
    input  logic                    mem_read_done,
    input  logic [XLEN-1:0]         mem_data,
    output logic                    read_mem_enable,
    output logic [PC_BITWIDTH-1:0]  read_mem_addr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    discard_q;
    logic [PC_BITWIDTH-1:0]  next_addr_q;
    logic                    read_mem_enable_q;
    logic [PC_BITWIDTH-1:0]  read_mem_addr_q;
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           count_d;

    logic [PC_BITWIDTH-1:0]  pc_mem [DEPTH];
    logic [XLEN-1:0]         ir_mem [DEPTH];

    logic pop;
    logic push;
    logic room;

    // A redirect wins over any same-cycle pop or push; room uses the post-update count.
    always_comb begin
        pop     = fetch_next && (count_q != '0) && !fetch_init;
        push    = mem_read_done && (state_q == S_WAIT) && !discard_q && !fetch_init;
        count_d = count_q;
        if (fetch_init) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
        end
        room = (count_d < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q] <= read_mem_addr_q;
            ir_mem[wr_ptr_q] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q           <= S_IDLE;
            discard_q         <= 1'b0;
            next_addr_q       <= '0;
            read_mem_enable_q <= 1'b0;
            read_mem_addr_q   <= '0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
        end else begin
            count_q           <= count_d;
            read_mem_enable_q <= 1'b0;
            if (fetch_init) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (fetch_init) begin
                        read_mem_enable_q <= 1'b1;
                        read_mem_addr_q   <= start_addr;
                        next_addr_q       <= start_addr + PC_BITWIDTH'(4);
                        state_q           <= S_WAIT;
                    end
                end
                S_FETCH: begin
                    if (fetch_init) begin
                        read_mem_enable_q <= 1'b1;
                        read_mem_addr_q   <= start_addr;
                        next_addr_q       <= start_addr + PC_BITWIDTH'(4);
                        state_q           <= S_WAIT;
                    end else if (room) begin
                        read_mem_enable_q <= 1'b1;
                        read_mem_addr_q   <= next_addr_q;
                        next_addr_q       <= next_addr_q + PC_BITWIDTH'(4);
                        state_q           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_read_done) begin
                        discard_q <= 1'b0;
                        if (fetch_init) begin
                            read_mem_enable_q <= 1'b1;
                            read_mem_addr_q   <= start_addr;
                            next_addr_q       <= start_addr + PC_BITWIDTH'(4);
                        end else if (room) begin
                            read_mem_enable_q <= 1'b1;
                            read_mem_addr_q   <= next_addr_q;
                            next_addr_q       <= next_addr_q + PC_BITWIDTH'(4);
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end else if (fetch_init) begin
                        // The in-flight response belongs to the old stream; drop it when it lands.
                        next_addr_q <= start_addr;
                        discard_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fetch_enable_out = (count_q != '0);
    assign IR_out           = fetch_enable_out ? ir_mem[rd_ptr_q] : NOP_WORD;
    assign PC_out           = fetch_enable_out ? pc_mem[rd_ptr_q] : '0;
    assign read_mem_enable  = read_mem_enable_q;
    assign read_mem_addr    = read_mem_addr_q;

endmodule

// File: tb/tb_rv2t_prefetch_queue.sv
// Bench for rv2t_prefetch_queue: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_rv2t_prefetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        sync_reset    = 1'b0;
    logic        fetch_init    = 1'b0;
    logic [31:0] start_addr    = '0;
    logic        fetch_next    = 1'b0;
    logic        mem_read_done = 1'b0;
    logic [31:0] mem_data      = '0;
    logic        fetch_enable_out;
    logic [31:0] IR_out;
    logic [31:0] PC_out;
    logic        read_mem_enable;
    logic [31:0] read_mem_addr;

    rv2t_prefetch_queue #(
        .XLEN(32), .PC_BITWIDTH(32), .DEPTH(DEPTH), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .sync_reset(sync_reset), .fetch_init(fetch_init),
        .start_addr(start_addr), .fetch_next(fetch_next),
        .fetch_enable_out(fetch_enable_out), .IR_out(IR_out), .PC_out(PC_out),
        .mem_read_done(mem_read_done), .mem_data(mem_data),
        .read_mem_enable(read_mem_enable), .read_mem_addr(read_mem_addr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue contents as an SV queue plus the fetch bookkeeping.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    ent_t        mq[$];
    bit          m_started = 0;
    bit          m_out     = 0;
    bit          m_disc    = 0;
    logic [31:0] m_next    = '0;
    logic [31:0] m_addr    = '0;
    bit          m_rme     = 0;

    function automatic void m_issue(input logic [31:0] a);
        m_rme     = 1;
        m_addr    = a;
        m_next    = a + 32'd4;
        m_out     = 1;
        m_started = 1;
    endfunction

    task automatic model_step();
        bit   acc;
        ent_t e;
        if (sync_reset) begin
            mq.delete();
            m_started = 0; m_out = 0; m_disc = 0;
            m_next = '0; m_addr = '0; m_rme = 0;
        end else begin
            m_rme = 0;
            acc   = m_started && m_out && mem_read_done;
            if (fetch_init) begin
                mq.delete();
                if (acc || !m_out) begin
                    m_disc = 0;
                    m_issue(start_addr);
                end else begin
                    m_next = start_addr;
                    m_disc = 1;
                end
            end else begin
                if (fetch_next && mq.size() > 0) void'(mq.pop_front());
                if (acc) begin
                    m_out = 0;
                    if (m_disc) begin
                        m_disc = 0;
                    end else begin
                        e.pc = m_addr;
                        e.ir = mem_data;
                        mq.push_back(e);
                    end
                end
                if (m_started && !m_out && mq.size() < DEPTH) m_issue(m_next);
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_ir;
        logic [31:0] exp_pc;
        if (mq.size() > 0) begin
            exp_ir = mq[0].ir;
            exp_pc = mq[0].pc;
        end else begin
            exp_ir = NOP;
            exp_pc = '0;
        end
        check("model_fetch_enable", 32'(fetch_enable_out), 32'(mq.size() > 0));
        check("model_IR", IR_out, exp_ir);
        check("model_PC", PC_out, exp_pc);
        check("model_rme", 32'(read_mem_enable), 32'(m_rme));
        check("model_raddr", read_mem_addr, m_addr);
    endtask

    // Memory: one response per request after a latency of lat cycles.
    bit          mem_pend  = 0;
    int          mem_cnt   = 0;
    logic [31:0] mem_paddr = '0;
    bit          rand_mode = 0;
    int          lat       = 2;

    task automatic mem_drive();
        mem_read_done = 1'b0;
        mem_data      = $urandom;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_read_done = 1'b1;
                mem_data      = rand_mode ? $urandom : (mem_paddr ^ 32'h5A00_0000);
                mem_pend      = 0;
            end
        end
        if (m_rme) begin
            mem_pend  = 1;
            mem_paddr = m_addr;
            mem_cnt   = rand_mode ? int'($urandom_range(1, 4)) : lat;
        end
    endtask

    int          req_cnt = 0;
    bit          rec_on  = 0;
    logic [31:0] addr_log[$];

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (read_mem_enable) begin
            req_cnt++;
            if (rec_on) addr_log.push_back(read_mem_addr);
        end
        fetch_init = 1'b0;
        fetch_next = 1'b0;
        sync_reset = 1'b0;
        mem_drive();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_fe"},    32'(fetch_enable_out), 32'd0);
        check({tag, "_ir"},    IR_out, 32'h0000_0013);
        check({tag, "_pc"},    PC_out, 32'd0);
        check({tag, "_rme"},   32'(read_mem_enable), 32'd0);
        check({tag, "_raddr"}, read_mem_addr, 32'd0);
    endtask

    initial begin
        logic [31:0] wrap_exp[3];
        logic [31:0] got;
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        sync_reset = 1'b1;
        step();
        check_reset_vals("reset");

        // Redirect to 0x100 and let the queue fill with L=2.
        fetch_init = 1'b1; start_addr = 32'h100; req_cnt = 0;
        step();
        check("t1_rme", 32'(read_mem_enable), 32'd1);
        check("t1_addr", read_mem_addr, 32'h100);
        repeat (3) step();
        check("t4_fe", 32'(fetch_enable_out), 32'd1);
        check("t4_pc", PC_out, 32'h100);
        check("t4_ir", IR_out, 32'h5A00_0100);
        check("t4_rme", 32'(read_mem_enable), 32'd1);
        check("t4_addr", read_mem_addr, 32'h104);
        repeat (20) step();
        check("fill_req_count", 32'(req_cnt), 32'd4);
        check("fill_head_pc", PC_out, 32'h100);

        // Drain in order; the freed slot triggers the 0x110 request.
        for (int i = 0; i < 4; i++) begin
            check("pop_pc", PC_out, 32'h100 + 32'(4 * i));
            fetch_next = 1'b1;
            step();
            if (i == 0) begin
                check("refill_rme", 32'(read_mem_enable), 32'd1);
                check("refill_addr", read_mem_addr, 32'h110);
            end
        end
        check("refill_head_pc", PC_out, 32'h110);
        fetch_next = 1'b1;
        step();
        check("empty_fe", 32'(fetch_enable_out), 32'd0);

        // Redirect while a read is outstanding.
        fetch_init = 1'b1; start_addr = 32'h200;
        step();
        check("redir_stale_done", 32'(mem_read_done), 32'd1);
        step();
        check("redir_rme", 32'(read_mem_enable), 32'd1);
        check("redir_addr", read_mem_addr, 32'h200);
        check("redir_fe", 32'(fetch_enable_out), 32'd0);
        repeat (3) step();
        check("redir_head_pc", PC_out, 32'h200);
        check("redir_head_ir", IR_out, 32'h5A00_0200);

        // Redirect, response and pop all in one cycle.
        for (int k = 0; k < 10 && !mem_read_done; k++) step();
        check("coinc_wait_done", 32'(mem_read_done), 32'd1);
        fetch_init = 1'b1; start_addr = 32'h300; fetch_next = 1'b1;
        step();
        check("coinc_fe", 32'(fetch_enable_out), 32'd0);
        check("coinc_rme", 32'(read_mem_enable), 32'd1);
        check("coinc_addr", read_mem_addr, 32'h300);

        // Address wrap at the top of the space.
        addr_log.delete(); rec_on = 1;
        fetch_init = 1'b1; start_addr = 32'hFFFF_FFF8;
        step();
        repeat (20) step();
        rec_on = 0;
        for (int i = 0; i < 3; i++) begin
            got = (i < addr_log.size()) ? addr_log[i] : 32'hDEAD_BEEF;
            check("wrap_addr", got, wrap_exp[i]);
        end

        // Reset while a read is outstanding; its late response must be ignored.
        for (int k = 0; k < 20 && !(m_out && mem_pend); k++) begin
            fetch_next = 1'b1;
            step();
        end
        check("rst_wait_pending", 32'(m_out && mem_pend), 32'd1);
        sync_reset = 1'b1;
        step();
        check_reset_vals("midrst");
        req_cnt = 0;
        repeat (8) step();
        check("midrst_fe_hold", 32'(fetch_enable_out), 32'd0);
        check("midrst_no_req", 32'(req_cnt), 32'd0);

        // Randomized traffic.
        rand_mode = 1;
        for (int n = 0; n < 2000; n++) begin
            fetch_next = ($urandom_range(0, 99) < ((n / 200) % 2 == 0 ? 70 : 20));
            if ($urandom_range(0, 99) < 4 && !(!m_started && mem_pend)) begin
                fetch_init = 1'b1;
                start_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            end
            if ($urandom_range(0, 299) == 0) sync_reset = 1'b1;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rv2t_prefetch_queue.md
# rv2t_prefetch_queue

Parametrised successor to the single-word instruction fetch stage. It prefetches sequential instruction words into a DEPTH-entry in-order queue, so the scheduler can pop one instruction per cycle while memory latency is hidden. It supports redirection (`fetch_init`) at any time, including while a read is outstanding; stale responses are discarded. It sits between the scheduler and the memory controller.

## Interface
Parameters:
- `XLEN`, 32: instruction word width.
- `PC_BITWIDTH`, 32: address width.
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `NOP_WORD`, 32'h0000_0013: value on `IR_out` when the queue is empty or in reset.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `sync_reset`  in  1  reset, synchronous, active-high (one clock; reset is synchronous and active-high).
- `fetch_init`  in  1  redirect pulse: flush the queue and fetch from `start_addr`.
- `start_addr`  in  PC_BITWIDTH  redirect target, sampled when `fetch_init`=1.
- `fetch_next`  in  1  pop the head entry; ignored when the queue is empty.
- `fetch_enable_out`  out  1  level: queue non-empty, so `IR_out`/`PC_out` are valid.
- `IR_out`  out  XLEN  head instruction, or `NOP_WORD` when empty.
- `PC_out`  out  PC_BITWIDTH  address of the head instruction, or 0 when empty.
- `mem_read_done`  in  1  one-cycle pulse; `mem_data` is valid for the oldest outstanding read.
- `mem_data`  in  XLEN  read data.
- `read_mem_enable`  out  1  registered one-cycle request pulse.
- `read_mem_addr`  out  PC_BITWIDTH  registered request address, held until the next request.

## Operation
- Storage: DEPTH entries of {PC, IR}; read/write pointers of log2(DEPTH) bits wrap naturally; `count` is log2(DEPTH)+1 bits.
- At most one memory read is outstanding at a time. Memory returns exactly one `mem_read_done` per request, at least 1 cycle after `read_mem_enable`.
- `next_addr` register: the address of the next request. It increments by 4 per issued request, modulo 2^PC_BITWIDTH (0xFFFF_FFFC wraps to 0).
- FSM states:
  - **IDLE**: reset state; no requests issued; `mem_read_done` ignored. On `fetch_init`: issue at `start_addr`, go to WAIT.
  - **FETCH**: no request outstanding.
    - On `fetch_init`: flush, issue at `start_addr`, go to WAIT.
    - Else if `count` < DEPTH: issue at `next_addr`, go to WAIT.
    - Else stay in FETCH.
    - `mem_read_done` is ignored.
  - **WAIT**: one read outstanding.
    - On `mem_read_done` with `discard`=0: push {`read_mem_addr`, `mem_data`}.
    - On `mem_read_done` with `discard`=1: drop the data and clear `discard`.
    - In either case, on `mem_read_done` the next request issues immediately if the post-update `count` < DEPTH (go to WAIT), else go to FETCH.
    - On `fetch_init` without `mem_read_done`: flush, `next_addr` ← `start_addr`, set `discard`, stay in WAIT.
    - On `fetch_init` and `mem_read_done` in the same cycle: flush, drop the data, issue at `start_addr`.
- Room rule: `count` after the same-cycle pop is used, so a full queue popped this cycle may issue.
- Flush: pointers and `count` are zeroed. A `fetch_init` in the same cycle as `fetch_next` or a push wins; that pop or push is discarded.
- Push and pop in the same cycle: `count` is unchanged and the head advances.
- `sync_reset` overrides everything, mid-operation included.
  - State → IDLE; queue and `discard` cleared; all outputs take their reset values.
  - A response arriving after reset is ignored because the FSM is in IDLE.

## Timing
- Reset values: `fetch_enable_out`=0, `IR_out`=`NOP_WORD`, `PC_out`=0, `read_mem_enable`=0, `read_mem_addr`=0.
- `fetch_init` at cycle t (no outstanding read):
  - t+1: `read_mem_enable`=1, `read_mem_addr`=`start_addr`.
  - t+1+L: `mem_read_done`.
  - t+2+L: `fetch_enable_out`=1 with `IR_out`=data and `PC_out`=`start_addr`, and the next request is issued in this same cycle.
- Steady state: one instruction per L+1 cycles; the queue absorbs scheduler stalls.
- `fetch_enable_out`, `IR_out` and `PC_out` are decoded from registered queue state with no combinational path from inputs.
- After a pop at cycle t, the new head is visible at t+1.
- `fetch_enable_out` is 0 from the cycle after `fetch_init` until the first post-redirect push.

## Test plan
- Reset, then `fetch_init` with `start_addr`=0x100 and a memory model of L=2:
  - requests at 0x100, 0x104, 0x108, 0x10C, spaced 3 cycles apart;
  - first valid head is PC 0x100 at t+4;
  - with no pops, the queue fills at DEPTH=4 and no 5th request is issued.
- Full queue, then `fetch_next` held for 4 cycles: PCs 0x100–0x10C pop in order; a request at 0x110 issues the cycle after the first pop; `fetch_enable_out` drops when the queue is empty.
- Redirect while WAIT (`fetch_init` to 0x200 before `mem_read_done`):
  - the old response is discarded and never appears on `IR_out`;
  - the next request is issued at 0x200 in the cycle after the stale `mem_read_done`;
  - the head becomes PC 0x200.
- `fetch_init` coincident with `mem_read_done` and `fetch_next`: the data is dropped, the queue is empty next cycle, and `read_mem_addr`=`start_addr` with `read_mem_enable`=1.
- `start_addr`=0xFFFF_FFF8: request addresses are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- `sync_reset` asserted during WAIT:
  - all outputs return to their reset values the next cycle;
  - the late `mem_read_done` is ignored and `fetch_enable_out` stays 0 until `fetch_init`.
